// File: rtl/mem_stage.sv
// MEM stage: EX/MEM latch, word-addressed data memory with MEM_LAT wait states, branch resolve, MEM/WB bundle.
// Optional macro MEM_BOUNDS_CHECK_EN: out-of-range accesses are suppressed/flagged instead of wrapping.
module mem_stage #(
  parameter int DEPTH   = 1024,
  parameter int MEM_LAT = 0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        flush,
  input  logic [2:0]  cont_MEM,
  input  logic [1:0]  cont_WB,
  input  logic [11:0] NPC_ADD,
  input  logic        ZERO,
  input  logic [31:0] ALU_result,
  input  logic [31:0] EX_B,
  input  logic [4:0]  EX_rd,
  output logic        stall,
  output logic        PCSrc,
  output logic [11:0] branch_target,
  output logic [70:0] MEM_WB,
  output logic        mem_err
);

  localparam int AW = $clog2(DEPTH);
`ifdef MEM_BOUNDS_CHECK_EN
  localparam bit BOUNDS_CHK = 1'b1;
`else
  localparam bit BOUNDS_CHK = 1'b0;
`endif

  typedef enum logic {S_IDLE, S_WAIT} state_t;

  state_t      r_state, w_state_nxt;
  logic [2:0]  r_cnt, w_cnt_nxt;
  logic [2:0]  r_cont_mem;
  logic [1:0]  r_cont_wb;
  logic [11:0] r_npc;
  logic        r_zero;
  logic [31:0] r_alu, r_b;
  logic [4:0]  r_rd;
  logic [70:0] r_mem_wb;
  logic        r_err;
  logic [31:0] r_mem [DEPTH];

  logic          w_memop, w_done, w_stall, w_oob;
  logic [AW-1:0] w_idx;
  logic [31:0]   w_lmd;

  assign w_memop = r_cont_mem[1] | r_cont_mem[0];
  assign w_idx   = r_alu[AW+1:2];
  assign w_oob   = BOUNDS_CHK & (|r_alu[31:AW+2]);

  // A write wins over a simultaneous read; out-of-range loads return a poison word.
  always_comb begin
    w_lmd = 32'h0;
    if (!r_cont_mem[0]) begin
      if (w_oob) w_lmd = 32'hDEADBEEF;
      else       w_lmd = r_mem[w_idx];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cont_mem <= '0;
      r_cont_wb  <= '0;
      r_npc      <= '0;
      r_zero     <= 1'b0;
      r_alu      <= '0;
      r_b        <= '0;
      r_rd       <= '0;
    end else if (!w_stall) begin
      if (flush) begin
        r_cont_mem <= '0;
        r_cont_wb  <= '0;
        r_zero     <= 1'b0;
      end else begin
        r_cont_mem <= cont_MEM;
        r_cont_wb  <= cont_WB;
        r_zero     <= ZERO;
      end
      r_npc <= NPC_ADD;
      r_alu <= ALU_result;
      r_b   <= EX_B;
      r_rd  <= EX_rd;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Stall is raised on the first cycle an access sits in the latch and released
  // one cycle before completion, so the next op is captured on the completion edge.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_done      = 1'b0;
    w_stall     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_memop) begin
          if (MEM_LAT == 0) begin
            w_done = 1'b1;
          end else begin
            w_stall     = 1'b1;
            w_state_nxt = S_WAIT;
            w_cnt_nxt   = 3'(MEM_LAT);
          end
        end
      end
      S_WAIT: begin
        if (r_cnt == 3'd1) begin
          w_done      = 1'b1;
          w_state_nxt = S_IDLE;
          w_cnt_nxt   = '0;
        end else begin
          w_stall   = 1'b1;
          w_cnt_nxt = r_cnt - 3'd1;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_mem_wb <= '0;
      r_err    <= 1'b0;
    end else begin
      r_err <= 1'b0;
      if (r_state == S_IDLE && !w_memop) begin
        r_mem_wb <= {r_cont_wb, 32'h0, r_alu, r_rd};
      end else if (w_done) begin
        r_mem_wb <= {r_cont_wb, w_lmd, r_alu, r_rd};
        r_err    <= w_oob;
      end else begin
        r_mem_wb <= '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n && w_done && r_cont_mem[0] && !w_oob) r_mem[w_idx] <= r_b;
  end

  assign stall         = w_stall;
  assign PCSrc         = r_cont_mem[2] & r_zero;
  assign branch_target = r_npc;
  assign MEM_WB        = r_mem_wb;
  assign mem_err       = r_err;

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: three instances (MEM_LAT 0/2/3) share one stimulus stream.
module tb_mem_stage;
  logic        clk = 1'b0;
  logic        rst_n, flush, zero;
  logic [2:0]  cont_mem;
  logic [1:0]  cont_wb;
  logic [11:0] npc;
  logic [31:0] alu, exb;
  logic [4:0]  rd;

  logic        st0, pc0, err0, st2, pc2, err2, st3, pc3, err3;
  logic [11:0] bt0, bt2, bt3;
  logic [70:0] wb0, wb2, wb3;

  int n_tests = 0;
  int n_fail  = 0;

`ifdef MEM_BOUNDS_CHECK_EN
  localparam bit BCHK = 1'b1;
`else
  localparam bit BCHK = 1'b0;
`endif

  always #5 clk = ~clk;

  mem_stage #(.DEPTH(1024), .MEM_LAT(0)) u0 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .cont_MEM(cont_mem), .cont_WB(cont_wb),
    .NPC_ADD(npc), .ZERO(zero), .ALU_result(alu), .EX_B(exb), .EX_rd(rd),
    .stall(st0), .PCSrc(pc0), .branch_target(bt0), .MEM_WB(wb0), .mem_err(err0));
  mem_stage #(.DEPTH(1024), .MEM_LAT(2)) u2 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .cont_MEM(cont_mem), .cont_WB(cont_wb),
    .NPC_ADD(npc), .ZERO(zero), .ALU_result(alu), .EX_B(exb), .EX_rd(rd),
    .stall(st2), .PCSrc(pc2), .branch_target(bt2), .MEM_WB(wb2), .mem_err(err2));
  mem_stage #(.DEPTH(1024), .MEM_LAT(3)) u3 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .cont_MEM(cont_mem), .cont_WB(cont_wb),
    .NPC_ADD(npc), .ZERO(zero), .ALU_result(alu), .EX_B(exb), .EX_rd(rd),
    .stall(st3), .PCSrc(pc3), .branch_target(bt3), .MEM_WB(wb3), .mem_err(err3));

  function automatic logic [70:0] mk(input logic [1:0] w, input logic [31:0] l,
                                     input logic [31:0] a, input logic [4:0] r);
    return {w, l, a, r};
  endfunction

  task automatic chk(input string tag, input logic [70:0] obs, input logic [70:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drv(input logic [2:0] cm, input logic [1:0] cw, input logic [11:0] n,
                     input logic z, input logic [31:0] a, input logic [31:0] b,
                     input logic [4:0] r);
    cont_mem = cm; cont_wb = cw; npc = n; zero = z; alu = a; exb = b; rd = r;
  endtask

  task automatic nop();
    drv(3'b000, 2'b00, 12'h0, 1'b0, 32'h0, 32'h0, 5'd0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  initial begin
    flush = 1'b0;
    nop();
    do_reset();

    // reset state
    chk("rst_wb0", wb0, 71'h0);
    chk("rst_stall0", 71'(st0), 71'h0);
    chk("rst_pcsrc0", 71'(pc0), 71'h0);
    chk("rst_err0", 71'(err0), 71'h0);
    chk("rst_stall2", 71'(st2), 71'h0);

    // SW then LW, zero wait states
    drv(3'b001, 2'b00, 12'h0, 1'b0, 32'h10, 32'hCAFEF00D, 5'd0);
    tick();
    drv(3'b010, 2'b11, 12'h0, 1'b0, 32'h10, 32'h0, 5'd5);
    tick();
    drv(3'b000, 2'b10, 12'h0, 1'b0, 32'h1234, 32'h0, 5'd7);
    tick();
    chk("lw_after_sw", wb0, mk(2'b11, 32'hCAFEF00D, 32'h10, 5'd5));
    chk("lat0_nostall", 71'(st0), 71'h0);
    nop();
    tick();
    chk("alu_op", wb0, mk(2'b10, 32'h0, 32'h1234, 5'd7));

    // branch resolve
    drv(3'b100, 2'b00, 12'h040, 1'b1, 32'h0, 32'h0, 5'd0);
    tick();
    chk("br_taken", 71'(pc0), 71'h1);
    chk("br_target", 71'(bt0), 71'h040);
    drv(3'b100, 2'b00, 12'h080, 1'b0, 32'h0, 32'h0, 5'd0);
    tick();
    chk("br_not_taken", 71'(pc0), 71'h0);
    chk("br_target2", 71'(bt0), 71'h080);

    // flush drops a store
    drv(3'b001, 2'b00, 12'h0, 1'b0, 32'h20, 32'h11111111, 5'd0);
    tick();
    flush = 1'b1;
    drv(3'b001, 2'b11, 12'h0, 1'b0, 32'h20, 32'h22222222, 5'd0);
    tick();
    flush = 1'b0;
    drv(3'b010, 2'b01, 12'h0, 1'b0, 32'h20, 32'h0, 5'd3);
    tick();
    chk("flush_bubble_wb", 71'(wb0[70:69]), 71'h0);
    nop();
    tick();
    chk("flush_mem_kept", wb0, mk(2'b01, 32'h11111111, 32'h20, 5'd3));

    // out-of-range store
    drv(3'b001, 2'b00, 12'h0, 1'b0, 32'h0, 32'h55555555, 5'd0);
    tick();
    drv(3'b001, 2'b00, 12'h0, 1'b0, 32'h1000, 32'h66666666, 5'd0);
    tick();
    nop();
    tick();
    chk("oob_sw_err", 71'(err0), 71'(BCHK));
    drv(3'b010, 2'b11, 12'h0, 1'b0, 32'h0, 32'h0, 5'd4);
    tick();
    nop();
    tick();
    chk("oob_word0", wb0, mk(2'b11, BCHK ? 32'h55555555 : 32'h66666666, 32'h0, 5'd4));
    chk("inrange_noerr", 71'(err0), 71'h0);
    drv(3'b010, 2'b01, 12'h0, 1'b0, 32'h1000, 32'h0, 5'd6);
    tick();
    nop();
    tick();
    chk("oob_lw", wb0, mk(2'b01, BCHK ? 32'hDEADBEEF : 32'h66666666, 32'h1000, 5'd6));
    chk("oob_lw_err", 71'(err0), 71'(BCHK));

    // two wait states
    do_reset();
    drv(3'b001, 2'b00, 12'h0, 1'b0, 32'h30, 32'hA5A5A5A5, 5'd0);
    tick();
    nop();
    for (int i = 0; i < 4; i++) tick();
    drv(3'b010, 2'b11, 12'h0, 1'b0, 32'h30, 32'h0, 5'd9);
    tick();
    chk("lat2_stall_c1", 71'(st2), 71'h1);
    drv(3'b000, 2'b10, 12'h0, 1'b0, 32'h99, 32'h0, 5'd1);
    tick();
    chk("lat2_stall_c2", 71'(st2), 71'h1);
    chk("lat2_bubble1", 71'(wb2[70:69]), 71'h0);
    tick();
    chk("lat2_stall_drop", 71'(st2), 71'h0);
    chk("lat2_bubble2", 71'(wb2[70:69]), 71'h0);
    tick();
    chk("lat2_lw", wb2, mk(2'b11, 32'hA5A5A5A5, 32'h30, 5'd9));
    chk("lat2_after", 71'(st2), 71'h0);
    drv(3'b100, 2'b00, 12'h123, 1'b1, 32'h0, 32'h0, 5'd0);
    tick();
    chk("lat2_held_op", wb2, mk(2'b10, 32'h0, 32'h99, 5'd1));
    chk("lat2_br_nostall", 71'(st2), 71'h0);
    chk("lat2_br_pcsrc", 71'(pc2), 71'h1);

    // reset aborts a store in WAIT (three wait states)
    do_reset();
    drv(3'b001, 2'b00, 12'h0, 1'b0, 32'h40, 32'h12345678, 5'd0);
    tick();
    nop();
    for (int i = 0; i < 5; i++) tick();
    drv(3'b001, 2'b00, 12'h0, 1'b0, 32'h40, 32'hBAD0BAD0, 5'd0);
    tick();
    nop();
    tick();
    chk("lat3_in_wait", 71'(st3), 71'h1);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("lat3_rst_stall", 71'(st3), 71'h0);
    chk("lat3_rst_wb", wb3, 71'h0);
    drv(3'b010, 2'b11, 12'h0, 1'b0, 32'h40, 32'h0, 5'd2);
    tick();
    nop();
    for (int i = 0; i < 4; i++) tick();
    chk("lat3_mem_kept", wb3, mk(2'b11, 32'h12345678, 32'h40, 5'd2));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
